io_pad_mux: RTL and testbench

- Wishbone-configurable pad multiplexer for the user area, replacing hard-wired per-pin assignments around a core.
- Each of NPADS pads routes to one of NFUNC sources: function 0 is register-driven GPIO; functions 1..NFUNC-1 are core peripheral channels (UART, SPI, JTAG, ...).
- Provides input synchronisers and a post-reset output-enable hold, so pads never drive while the core is coming out of reset.
- Sits between the core wrapper and the io_in/io_out/io_oeb pad ring.

---
 rtl/io_pad_mux.sv | 219 +++++++++++++++++++++
 tb/tb_io_pad_mux.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pad_mux.sv
// io_pad_mux: Wishbone-configurable pad multiplexer between the core and the pad ring.
// Every pad picks one of NFUNC sources (0 = register GPIO, 1..NFUNC-1 = core peripherals).
// Pad inputs are synchronised; outputs are held tristated until the post-reset hold expires.
// Optional build macro IO_PAD_MUX_LOCK_EN adds a write-once lock that freezes the SEL registers.
module io_pad_mux #(
  parameter int NPADS       = 38,
  parameter int NFUNC       = 4,
  parameter int RST_HOLD    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [31:0]                  wbs_dat_i,
  input  logic [31:0]                  wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [31:0]                  wbs_dat_o,
  input  logic [NPADS*(NFUNC-1)-1:0]   fn_out,
  input  logic [NPADS*(NFUNC-1)-1:0]   fn_oe,
  output logic [NPADS-1:0]             fn_in,
  input  logic [NPADS-1:0]             io_in,
  output logic [NPADS-1:0]             io_out,
  output logic [NPADS-1:0]             io_oeb,
  output logic                         pads_ready
);

  localparam int SELW = $clog2(NFUNC);
  localparam int FPW  = 32 / SELW;
  localparam int HW   = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  logic              req;
  logic              wr;
  logic [5:0]        idx;
  logic [31:0]       wmask;
  logic [31:0]       rdata;
  logic              locked;

  logic [SELW-1:0]   sel_q [NPADS];
  logic [SELW-1:0]   sel_d [NPADS];
  logic [NPADS-1:0]  gpio_out_q;
  logic [NPADS-1:0]  gpio_oe_q;
  logic [63:0]       gpio_out_x;
  logic [63:0]       gpio_oe_x;
  logic [63:0]       gpio_in_x;
  logic [63:0]       gpio_out_d64;
  logic [63:0]       gpio_oe_d64;

  logic [NPADS-1:0]  sync_q [SYNC_STAGES];
  logic [HW-1:0]     hold_cnt;
  logic [NPADS-1:0]  out_d;
  logic [NPADS-1:0]  oe_d;
  logic [NPADS-1:0]  out_q;
  logic [NPADS-1:0]  oe_q;

  logic              unused_ok;

  assign idx   = wbs_adr_i[7:2];
  assign req   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr    = req & wbs_we_i;
  assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign fn_in = sync_q[SYNC_STAGES-1];

  assign unused_ok = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], gpio_out_d64, gpio_oe_d64};

  // Zero-extend the per-pad registers to the 64-bit lo/hi register view.
  always_comb begin
    gpio_out_x = '0;
    gpio_oe_x  = '0;
    gpio_in_x  = '0;
    gpio_out_x[NPADS-1:0] = gpio_out_q;
    gpio_oe_x[NPADS-1:0]  = gpio_oe_q;
    gpio_in_x[NPADS-1:0]  = fn_in;
  end

  // Post-reset hold: count down, flag ready on the edge the count reaches zero.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hold_cnt   <= HW'(RST_HOLD);
      pads_ready <= (RST_HOLD == 0);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) pads_ready <= 1'b1;
    end
  end

  // Input synchroniser chain on every pad.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // GPIO register next values with per-byte write strobes.
  always_comb begin
    gpio_out_d64 = gpio_out_x;
    gpio_oe_d64  = gpio_oe_x;
    if (wr) begin
      case (idx)
        6'd16: gpio_out_d64[31:0]  = (gpio_out_x[31:0]  & ~wmask) | (wbs_dat_i & wmask);
        6'd17: gpio_out_d64[63:32] = (gpio_out_x[63:32] & ~wmask) | (wbs_dat_i & wmask);
        6'd18: gpio_oe_d64[31:0]   = (gpio_oe_x[31:0]   & ~wmask) | (wbs_dat_i & wmask);
        6'd19: gpio_oe_d64[63:32]  = (gpio_oe_x[63:32]  & ~wmask) | (wbs_dat_i & wmask);
        default: ;
      endcase
    end
  end

  // SEL field next values; a field spans only its own bits, so byte strobes mask per bit.
  always_comb begin
    for (int p = 0; p < NPADS; p++) begin
      sel_d[p] = sel_q[p];
      if (wr && (idx < 6'd16) && !locked && (p / FPW == int'(idx))) begin
        sel_d[p] = (sel_q[p] & ~wmask[(p % FPW) * SELW +: SELW]) |
                   (wbs_dat_i[(p % FPW) * SELW +: SELW] & wmask[(p % FPW) * SELW +: SELW]);
      end
    end
  end

  // Configuration registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gpio_out_q <= '0;
      gpio_oe_q  <= '0;
      for (int p = 0; p < NPADS; p++) sel_q[p] <= '0;
    end else begin
      gpio_out_q <= gpio_out_d64[NPADS-1:0];
      gpio_oe_q  <= gpio_oe_d64[NPADS-1:0];
      for (int p = 0; p < NPADS; p++) sel_q[p] <= sel_d[p];
    end
  end

`ifdef IO_PAD_MUX_LOCK_EN
  // Write-once lock; only reset releases it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      locked <= 1'b0;
    end else if (wr && (idx == 6'd23) && wbs_sel_i[0] && (wbs_dat_i == 32'h0000_00A5)) begin
      locked <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  // Read decode; unmapped words and bits beyond NPADS read zero.
  always_comb begin
    rdata = '0;
    if (idx < 6'd16) begin
      for (int p = 0; p < NPADS; p++) begin
        if (p / FPW == int'(idx)) rdata[(p % FPW) * SELW +: SELW] = sel_q[p];
      end
    end else begin
      case (idx)
        6'd16:   rdata = gpio_out_x[31:0];
        6'd17:   rdata = gpio_out_x[63:32];
        6'd18:   rdata = gpio_oe_x[31:0];
        6'd19:   rdata = gpio_oe_x[63:32];
        6'd20:   rdata = gpio_in_x[31:0];
        6'd21:   rdata = gpio_in_x[63:32];
        6'd22:   rdata = {30'd0, locked, pads_ready};
`ifdef IO_PAD_MUX_LOCK_EN
        6'd23:   rdata = {31'd0, locked};
`endif
        default: rdata = '0;
      endcase
    end
  end

  // Single-cycle ack; read data only accompanies a read ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  // Per-pad source selection; out-of-range selects leave the pad undriven.
  always_comb begin
    for (int p = 0; p < NPADS; p++) begin
      out_d[p] = 1'b0;
      oe_d[p]  = 1'b0;
      if (sel_q[p] == '0) begin
        out_d[p] = gpio_out_q[p];
        oe_d[p]  = gpio_oe_q[p];
      end else begin
        for (int f = 1; f < NFUNC; f++) begin
          if (sel_q[p] == SELW'(f)) begin
            out_d[p] = fn_out[p * (NFUNC - 1) + f - 1];
            oe_d[p]  = fn_oe[p * (NFUNC - 1) + f - 1];
          end
        end
      end
    end
  end

  // Registered pad drive.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q <= '0;
      oe_q  <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
    end
  end

  assign io_out = out_q & {NPADS{pads_ready}};
  assign io_oeb = ~oe_q | {NPADS{~pads_ready}};

endmodule

// File: tb/tb_io_pad_mux.sv
module tb_io_pad_mux;

  localparam int NPADS       = 38;
  localparam int NFUNC       = 4;
  localparam int RST_HOLD    = 16;
  localparam int SYNC_STAGES = 2;
  localparam int SELW        = $clog2(NFUNC);
  localparam int FPW         = 32 / SELW;
  localparam int NFO         = NPADS * (NFUNC - 1);
  localparam logic [63:0] PADMASK = (NPADS == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << NPADS) - 64'd1);
`ifdef IO_PAD_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stb = 1'b0;
  logic             cyc = 1'b0;
  logic             we  = 1'b0;
  logic [3:0]       sel = 4'h0;
  logic [31:0]      dat_i = '0;
  logic [31:0]      adr = '0;
  logic             ack;
  logic [31:0]      dat_o;
  logic [NFO-1:0]   fn_out = '0;
  logic [NFO-1:0]   fn_oe = '0;
  logic [NPADS-1:0] fn_in;
  logic [NPADS-1:0] io_in = '0;
  logic [NPADS-1:0] io_out;
  logic [NPADS-1:0] io_oeb;
  logic             pads_ready;

  io_pad_mux #(.NPADS(NPADS), .NFUNC(NFUNC), .RST_HOLD(RST_HOLD), .SYNC_STAGES(SYNC_STAGES)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .fn_out(fn_out), .fn_oe(fn_oe), .fn_in(fn_in), .io_in(io_in), .io_out(io_out),
    .io_oeb(io_oeb), .pads_ready(pads_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_sel [NPADS];
  logic [63:0] m_gout;
  logic [63:0] m_goe;
  logic        m_ready;
  logic        m_lock;

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    int          addr;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    logic [63:0] ix;
    logic [31:0] r;
    int w;
    w  = a / 4;
    r  = '0;
    ix = '0;
    ix[NPADS-1:0] = io_in;
    if (w < 16) begin
      for (int k = 0; k < FPW; k++) begin
        int p;
        p = w * FPW + k;
        if (p < NPADS) r = r | (32'(m_sel[p]) << (k * SELW));
      end
    end else begin
      case (w)
        16: r = m_gout[31:0];
        17: r = m_gout[63:32];
        18: r = m_goe[31:0];
        19: r = m_goe[63:32];
        20: r = ix[31:0];
        21: r = ix[63:32];
        22: r = {30'd0, m_lock, m_ready};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    int w;
    w = a / 4;
    m = merge(model_read(a), d, s);
    if (w < 16) begin
      if (!m_lock) begin
        for (int k = 0; k < FPW; k++) begin
          int p;
          p = w * FPW + k;
          if (p < NPADS) m_sel[p] = int'((m >> (k * SELW)) & ((32'd1 << SELW) - 32'd1));
        end
      end
    end else begin
      case (w)
        16: m_gout[31:0]  = m;
        17: m_gout[63:32] = m;
        18: m_goe[31:0]   = m;
        19: m_goe[63:32]  = m;
        23: if (LOCK_EN && s[0] && d == 32'h0000_00A5) m_lock = 1'b1;
        default: ;
      endcase
      m_gout = m_gout & PADMASK;
      m_goe  = m_goe & PADMASK;
    end
  endtask

  task automatic wb(input bit w, input int a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    bit got;
    e.is_rd = !w;
    e.exp   = model_read(a);
    e.addr  = a;
    sb.push_back(e);
    if (w) model_write(a, d, s);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = 32'(a); dat_i = d; sel = s;
    got = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL wb_ack_timeout: no ack for addr %h", a);
      sb.delete();
    end
  endtask

  task automatic check_pads();
    logic [NPADS-1:0] eo, eb;
    for (int p = 0; p < NPADS; p++) begin
      if (!m_ready) begin
        eo[p] = 1'b0; eb[p] = 1'b1;
      end else if (m_sel[p] == 0) begin
        eo[p] = m_gout[p]; eb[p] = !m_goe[p];
      end else if (m_sel[p] < NFUNC) begin
        eo[p] = fn_out[p * (NFUNC - 1) + m_sel[p] - 1];
        eb[p] = !fn_oe[p * (NFUNC - 1) + m_sel[p] - 1];
      end else begin
        eo[p] = 1'b0; eb[p] = 1'b1;
      end
    end
    chk("io_out", 64'(io_out), 64'(eo));
    chk("io_oeb", 64'(io_oeb), 64'(eb));
    chk("pads_ready", 64'(pads_ready), 64'(m_ready));
  endtask

  task automatic settle_check();
    @(posedge clk); #1;
    check_pads();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    sb.delete();
    for (int p = 0; p < NPADS; p++) m_sel[p] = 0;
    m_gout = '0; m_goe = '0; m_lock = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_io_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
    chk("rst_io_out", 64'(io_out), 64'(0));
    chk("rst_fn_in", 64'(fn_in), 64'(0));
    chk("rst_ack_dat", {31'd0, ack, dat_o}, 64'(0));
    chk("rst_pads_ready", 64'(pads_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 40 && !pads_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!pads_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: pads_ready %0d required 1", pads_ready);
    end
    m_ready = 1'b1;
  endtask

  // Scoreboard monitor: every ack consumes one expected entry; reads compare data.
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ack_prev <= 1'b0;
    end else begin
      if (ack) begin
        chk("ack_single_cycle", 64'(ack_prev), 64'(0));
        if (sb.size() == 0) begin
          chk("unexpected_ack", 64'(sb.size()), 64'(1));
        end else begin
          e = sb.pop_front();
          if (e.is_rd) chk($sformatf("rdata@%02h", e.addr), 64'(dat_o), 64'(e.exp));
        end
      end
      ack_prev <= ack;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, op;
    // Reset and hold window
    do_reset();
    for (int i = 1; i <= RST_HOLD; i++) begin
      @(posedge clk); #1;
      chk("hold_pads_ready", 64'(pads_ready), 64'(i == RST_HOLD));
      chk("hold_io_oeb", 64'(io_oeb), 64'({NPADS{1'b1}}));
    end
    m_ready = 1'b1;
    wb(0, 'h58, 0, 4'hF);

    // GPIO drive after ready
    wb(1, 'h48, 32'h1, 4'hF);
    wb(1, 'h40, 32'h1, 4'hF);
    settle_check();

    // Same writes during the hold: pad stays off, then drives once ready
    do_reset();
    wb(1, 'h48, 32'h1, 4'hF);
    settle_check();
    wb(1, 'h40, 32'h1, 4'hF);
    settle_check();
    wait_ready();
    settle_check();

    // Pad 1 to function 1
    wb(1, 'h00, 32'h4, 4'hF);
    fn_oe[3] = 1'b1;
    fn_out[3] = 1'b1;
    settle_check();
    fn_out[3] = 1'b0;
    chk("fn_latency_io_out1", 64'(io_out[1]), 64'(1));
    settle_check();
    wb(0, 'h00, 0, 4'hF);

    // Input synchroniser
    io_in = '0;
    repeat (3) @(posedge clk);
    #1;
    io_in[5] = 1'b1;
    @(posedge clk); #1;
    chk("fn_in5_stage1", 64'(fn_in[5]), 64'(0));
    @(posedge clk); #1;
    chk("fn_in_synced", 64'(fn_in), 64'(io_in));
    wb(0, 'h50, 0, 4'hF);

    // Byte strobes, unmapped address
    wb(1, 'h40, 32'h0, 4'hF);
    wb(1, 'h40, 32'hFFFF_FFFF, 4'b0010);
    wb(0, 'h40, 0, 4'hF);
    wb(1, 'h44, 32'hFFFF_FFFF, 4'hF);
    wb(0, 'h44, 0, 4'hF);
    wb(1, 'h60, 32'hDEAD_BEEF, 4'hF);
    wb(0, 'h60, 0, 4'hF);
    wb(1, 'h50, 32'hFFFF_FFFF, 4'hF);
    wb(0, 'h50, 0, 4'hF);

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          a = int'($urandom_range(0, 25)) * 4;
          if (a == 'h5C) a = 'h58;
          wb(1, a, $urandom(), 4'($urandom_range(0, 15)));
          settle_check();
        end
        1: begin
          a = int'($urandom_range(0, 63)) * 4;
          if (LOCK_EN && a == 'h5C) a = 'h58;
          wb(0, a, 0, 4'hF);
        end
        2: begin
          for (int i = 0; i < NFO; i++) begin
            fn_out[i] = ($urandom_range(0, 1) != 0);
            fn_oe[i]  = ($urandom_range(0, 1) != 0);
          end
          settle_check();
        end
        default: begin
          for (int i = 0; i < NPADS; i++) io_in[i] = ($urandom_range(0, 1) != 0);
          repeat (SYNC_STAGES) @(posedge clk);
          #1;
          chk("fn_in_rand", 64'(fn_in), 64'(io_in));
        end
      endcase
    end

    // Lock behaviour (0x5C unmapped when the lock is not built in)
    wb(1, 'h00, 32'h0, 4'hF);
    wb(1, 'h5C, 32'hA5, 4'h1);
    wb(1, 'h00, 32'h8, 4'hF);
    wb(0, 'h00, 0, 4'hF);
    wb(0, 'h58, 0, 4'hF);
    settle_check();
    do_reset();
    wait_ready();
    wb(0, 'h58, 0, 4'hF);
    wb(1, 'h00, 32'h8, 4'hF);
    wb(0, 'h00, 0, 4'hF);
    settle_check();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
